lpif_tx_control_dataflow: RTL

- Transmit-direction counterpart of the LPIF RX control/dataflow block.
- Accepts 512-bit (64-byte) beats from the link layer over the LPIF lp_* interface, with per-byte TLP/DLLP framing masks.
- Buffers beats in a 2-entry FIFO, tracks packet-open state, checks framing and gates traffic on LTSSM link-up.
- Presents beats to the PHY TX framer with a valid/ready handshake. Byte index 63 (data[511:504]) is first on the wire.

---
 rtl/lpif_tx_control_dataflow.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/lpif_tx_control_dataflow.sv
// LPIF transmit control/dataflow.
// Takes 64-byte beats from the link layer (lp_* with per-byte framing masks),
// buffers them in a 2-entry FIFO, tracks whether a TLP/DLLP is open, flags
// framing violations and flushes everything when the LTSSM leaves link-up.
// The head beat is presented to the PHY TX framer with tx_valid/tx_ready.
// Byte 63 (data[511:504]) is first on the wire.
//
// Ports:
//   clk, reset            clock, async active-low reset
//   lp_*                  link-layer beat, handshake and force-detect request
//   GEN, state            current generation and LTSSM state
//   tx_ready              framer accepts the head beat
//   pl_trdy               beat accepted this cycle if lp_irdy
//   tx_valid, packet*...  head beat and its masks (zero when empty)
//   tx_abort              one-cycle pulse when traffic is flushed on link drop
//   framing_error         sticky framing violation
//   pl_state_sts, pl_speedmode, ltssmForceDetect  registered status

module lpif_tx_control_dataflow #(
  parameter logic [3:0]  LINK_UP_STATE = 4'd3,
  parameter int unsigned DEPTH         = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         lp_irdy,
  input  logic [511:0] lp_data,
  input  logic [63:0]  lp_valid,
  input  logic [63:0]  lp_tlpstart,
  input  logic [63:0]  lp_dllpstart,
  input  logic [63:0]  lp_tlpend,
  input  logic [63:0]  lp_dllpend,
  input  logic [63:0]  lp_tlpedb,
  input  logic         lp_force_detect,
  input  logic [2:0]   GEN,
  input  logic [3:0]   state,
  input  logic         tx_ready,
  output logic         pl_trdy,
  output logic         tx_valid,
  output logic [511:0] packetData,
  output logic [63:0]  packetValid,
  output logic [63:0]  tlpstart,
  output logic [63:0]  dllpstart,
  output logic [63:0]  tlpend,
  output logic [63:0]  dllpend,
  output logic [63:0]  edb,
  output logic         tx_abort,
  output logic         framing_error,
  output logic [3:0]   pl_state_sts,
  output logic [2:0]   pl_speedmode,
  output logic         ltssmForceDetect
);

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  valid;
    logic [63:0]  tlpstart;
    logic [63:0]  dllpstart;
    logic [63:0]  tlpend;
    logic [63:0]  dllpend;
    logic [63:0]  edb;
  } beat_t;

  typedef enum logic [1:0] {StIdle, StInTlp, StInDllp} trk_e;

  localparam logic [1:0] Full = 2'(DEPTH);

  beat_t      in_beat, ent0_q, ent0_d, ent1_q, ent1_d, head;
  logic [1:0] count_q, count_d;
  trk_e       trk_q, trk_d, trk_beat;
  logic       tx_abort_q, tx_abort_d;
  logic       framing_error_q, framing_error_d;
  logic [3:0] pl_state_sts_q;
  logic [2:0] pl_speedmode_q;
  logic       force_detect_q;
  logic       link_up, push, pop, flush, beat_err;
  logic [63:0] start_m, end_m;

  assign in_beat = '{data: lp_data, valid: lp_valid, tlpstart: lp_tlpstart,
                     dllpstart: lp_dllpstart, tlpend: lp_tlpend, dllpend: lp_dllpend,
                     edb: lp_tlpedb};

  assign link_up  = (state == LINK_UP_STATE) && !lp_force_detect;
  assign tx_valid = (count_q != 2'd0);
  assign pl_trdy  = link_up && (count_q != Full);
  assign push     = lp_irdy && pl_trdy;
  assign pop      = tx_valid && tx_ready;
  // Any buffered beat or open packet must be discarded once the link drops.
  assign flush    = !link_up && (tx_valid || (trk_q != StIdle));

  assign start_m = lp_tlpstart | lp_dllpstart;
  assign end_m   = lp_tlpend | lp_dllpend | lp_tlpedb;

  // Scan from byte 63 (first on wire) down to byte 0 so the last marker seen
  // decides the tracking state, and "start at a higher index" is a running flag.
  always_comb begin
    logic seen_tlp, seen_dllp;
    trk_beat  = trk_q;
    beat_err  = 1'b0;
    seen_tlp  = 1'b0;
    seen_dllp = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      if ((start_m[i] || end_m[i]) && !lp_valid[i]) beat_err = 1'b1;
      if (start_m[i] && end_m[i]) beat_err = 1'b1;
      if (lp_tlpend[i] && lp_tlpedb[i]) beat_err = 1'b1;
      if ((lp_tlpend[i] || lp_tlpedb[i]) && !seen_tlp && (trk_q != StInTlp)) beat_err = 1'b1;
      if (lp_dllpend[i] && !seen_dllp && (trk_q != StInDllp)) beat_err = 1'b1;
      if (end_m[i]) trk_beat = StIdle;
      if (lp_tlpstart[i]) trk_beat = StInTlp;
      if (lp_dllpstart[i]) trk_beat = StInDllp;
      if (lp_tlpstart[i]) seen_tlp = 1'b1;
      if (lp_dllpstart[i]) seen_dllp = 1'b1;
    end
  end

  // Entry 0 is always the head; entry 1 holds the second beat when full.
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    trk_d   = trk_q;
    if (flush) begin
      count_d = 2'd0;
      trk_d   = StIdle;
    end else begin
      if (push) trk_d = trk_beat;
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) ent0_d = in_beat;
          else                 ent1_d = in_beat;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // count is 1 here: full FIFO cannot push.
          ent0_d = in_beat;
        end
        default: ;
      endcase
    end
    tx_abort_d      = flush;
    framing_error_d = framing_error_q || (push && beat_err);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent0_q          <= '0;
      ent1_q          <= '0;
      count_q         <= 2'd0;
      trk_q           <= StIdle;
      tx_abort_q      <= 1'b0;
      framing_error_q <= 1'b0;
      pl_state_sts_q  <= 4'd0;
      pl_speedmode_q  <= 3'd0;
      force_detect_q  <= 1'b0;
    end else begin
      ent0_q          <= ent0_d;
      ent1_q          <= ent1_d;
      count_q         <= count_d;
      trk_q           <= trk_d;
      tx_abort_q      <= tx_abort_d;
      framing_error_q <= framing_error_d;
      pl_state_sts_q  <= state;
      pl_speedmode_q  <= GEN;
      force_detect_q  <= lp_force_detect;
    end
  end

  assign head             = tx_valid ? ent0_q : '0;
  assign packetData       = head.data;
  assign packetValid      = head.valid;
  assign tlpstart         = head.tlpstart;
  assign dllpstart        = head.dllpstart;
  assign tlpend           = head.tlpend;
  assign dllpend          = head.dllpend;
  assign edb              = head.edb;
  assign tx_abort         = tx_abort_q;
  assign framing_error    = framing_error_q;
  assign pl_state_sts     = pl_state_sts_q;
  assign pl_speedmode     = pl_speedmode_q;
  assign ltssmForceDetect = force_detect_q;

endmodule
